// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the nibble-serial adder.
//   nsa_state_t : controller state (IDLE, RUN, DONE)
//   NIBBLE_W    : bits consumed per RUN cycle
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/four_bit_adder.sv
// four_bit_adder: combinational 4-bit adder with carry in/out.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit result
//   cout : carry out of bit 3
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Five-bit add so the carry falls out as the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands one nibble per cycle through
// a single four_bit_adder, carrying between nibbles in a register.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (op_a, op_b, carry_in)
//   out_valid / out_ready: result handshake (sum, carry_out, overflow)
//   sum                  : op_a + op_b + carry_in mod 2**WIDTH
//   carry_out            : carry out of the MSB nibble
//   overflow             : two's complement overflow
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  nsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       add_sum;
  logic             add_cout;

  four_bit_adder u_adder (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = carry_in;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_b[WIDTH-1];
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        // New nibble enters at the top; after NIB cycles nibble 0 sits at the bottom.
        sum_d   = WIDTH'({add_sum, sum_q} >> NIBBLE_W);
        carry_d = add_cout;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = DONE;
          cout_d  = add_cout;
          // Overflow: like-signed operands giving a result of the other sign.
          ovf_d   = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
